mem_bus_responder: RTL and testbench
====================================

// Module: mem_bus_responder
//
// PURPOSE
// Memory-side responder for the cache fill/writeback bus (HRequest/HAddr/HRData/BusReady).
// Sits behind the instruction and data caches (via the bus arbiter) and services one
// 32-bit word per transaction from an internal word-addressed memory array.
// Inserts a programmable number of wait states so that cache stall and fill-counter
// logic is exercised under realistic latency.
//
// PARAMETERS
// WORDS    1024  memory depth in 32-bit words; power of two, >= 4
// LATENCY  2     wait cycles between request capture and BusReady; range 0..15
//
// PORTS
// clk        in   1   single clock; all state updates on rising edge
// reset      in   1   asynchronous, active-high reset
// HRequest   in   1   bus request; sampled only in IDLE
// HWrite     in   1   1 = write, 0 = read; sampled with HRequest
// HAddr      in   32  byte address; word index = HAddr[$clog2(WORDS)+1:2]
// HWData     in   32  write data; sampled with HRequest
// HRData     out  32  read data (registered); valid while BusReady = 1
// BusReady   out  1   one-cycle completion pulse for the current transaction
//
// BEHAVIOUR
// - Reset (async, active-high): state <= IDLE, BusReady = 0, HRData = 0, counter = 0.
//   Memory contents are NOT cleared; reset mid-transaction abandons it (no write occurs).
// - FSM states: IDLE, WAIT, DONE.
//   IDLE: if HRequest = 1, capture HWrite/HAddr/HWData, counter <= LATENCY;
//         next = DONE when LATENCY == 0, else WAIT. If HRequest = 0, stay in IDLE.
//   WAIT: counter decrements by 1 each cycle; when counter == 1, next = DONE.
//   DONE: BusReady = 1 for exactly this cycle; next = IDLE unconditionally.
// - Latency: with HRequest first high in cycle 0 (IDLE), BusReady is high in cycle
//   LATENCY+1. Minimum throughput is one word per 2 cycles (DONE always returns to IDLE).
// - Data path (on the edge entering DONE):
//   read:  HRData <= mem[idx]
//   write: mem[idx] <= HWData; HRData <= HWData (written value echoed)
// - HRData holds its value outside DONE. BusReady is a registered FSM decode (no glitch).
// - Transaction is committed at capture: HRequest dropping, or HAddr/HWData changing
//   during WAIT, has no effect. HRequest still high in the cycle after DONE starts a new
//   transaction using the address presented then (cache advances word offset on BusReady).
// - Address: HAddr[1:0] ignored; bits above $clog2(WORDS)+1 ignored (aliasing, no error).
// - Counter width is 4 bits; LATENCY outside 0..15 is a static elaboration error.
//
// CONFIGURATION
// MEMRESP_BYTEMASK_EN defined: adds input port HByteMask (4 bits, sampled with HRequest).
//   A write updates only byte lanes whose mask bit is 1 (bit i -> bits [8i+7:8i]).
//   HRData in DONE returns the full merged word. Reads ignore the mask.
// MEMRESP_BYTEMASK_EN undefined: no HByteMask port; every write updates all 4 bytes.
//
// TESTING
// 1. Assert reset mid-cycle, with no clock edge -> BusReady = 0 and HRData = 0
//    immediately; FSM is in IDLE.
// 2. LATENCY = 2: write 0xDEADBEEF to 0x10 in cycle 0 -> BusReady high only in cycle 3.
//    Then read 0x10 -> HRData = 0xDEADBEEF with a single BusReady pulse.
// 3. Line fill: preload 0x20/24/28/2C = 1/2/3/4, hold HRequest, and advance HAddr on each
//    BusReady -> 4 pulses, 2+LATENCY cycles apart, returning 1, 2, 3, 4 in order.
// 4. WORDS = 1024: write 0x55 to 0x10, then read 0x1010 -> 0x55 (alias). Also read 0x13
//    -> 0x55 (low bits ignored).
// 5. Assert reset during WAIT of a write of 0x1234 to 0x40 (old value 0x9) -> BusReady
//    never pulses. A later read of 0x40 returns 0x9 after the normal latency.
// 6. LATENCY = 0: request in cycle 0 -> BusReady in cycle 1. With MEMRESP_BYTEMASK_EN,
//    write 0x11223344 with mask 4'b0011 over 0xAABBCCDD -> a read returns 0xAABB3344.

Source files
------------

// File: rtl/mem_bus_responder.sv
// Memory-side responder for the cache fill/writeback bus: one 32-bit word per transaction
// after LATENCY wait states. Define MEMRESP_BYTEMASK_EN to add the HByteMask write-lane input.
module mem_bus_responder #(
  parameter int WORDS   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        HRequest,
  input  logic        HWrite,
  input  logic [31:0] HAddr,
  input  logic [31:0] HWData,
`ifdef MEMRESP_BYTEMASK_EN
  input  logic [3:0]  HByteMask,
`endif
  output logic [31:0] HRData,
  output logic        BusReady
);

  localparam int         IW  = $clog2(WORDS);
  localparam logic [3:0] LAT = 4'(LATENCY);

  if (LATENCY < 0 || LATENCY > 15 || WORDS < 4 || (WORDS & (WORDS - 1)) != 0) begin : g_param_check
    $error("mem_bus_responder: LATENCY must be 0..15 and WORDS a power of two >= 4");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r, next_state_s;
  logic [3:0]      cnt_r, cnt_next_s;
  logic            cap_s;
  logic            wr_r;
  logic [IW-1:0]   idx_r;
  logic [31:0]     wdata_r;
  logic [3:0]      mask_r;
  logic            op_wr_s;
  logic [IW-1:0]   op_idx_s;
  logic [31:0]     op_wdata_s;
  logic [3:0]      op_mask_s;
  logic [3:0]      in_mask_s;
  logic [31:0]     rd_word_s;
  logic [31:0]     merged_s;
  logic            enter_done_s;
  logic [31:0]     mem [WORDS];
  logic            unused_addr_s;

  assign unused_addr_s = ^{HAddr[31:IW+2], HAddr[1:0]};

`ifdef MEMRESP_BYTEMASK_EN
  assign in_mask_s = HByteMask;
`else
  assign in_mask_s = 4'hF;
`endif

  // Next-state, counter reload/decrement and request capture strobe
  always_comb begin
    next_state_s = state_r;
    cnt_next_s   = cnt_r;
    cap_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (HRequest) begin
          cap_s        = 1'b1;
          cnt_next_s   = LAT;
          next_state_s = (LAT == 4'd0) ? DONE : WAIT;
        end else begin
          next_state_s = IDLE;
        end
      end
      WAIT: begin
        cnt_next_s = cnt_r - 4'd1;
        if (cnt_r == 4'd1) begin
          next_state_s = DONE;
        end else begin
          next_state_s = WAIT;
        end
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // With zero latency the edge entering DONE is the capture edge, so use live inputs there
  always_comb begin
    if (state_r == IDLE) begin
      op_wr_s    = HWrite;
      op_idx_s   = HAddr[IW+1:2];
      op_wdata_s = HWData;
      op_mask_s  = in_mask_s;
    end else begin
      op_wr_s    = wr_r;
      op_idx_s   = idx_r;
      op_wdata_s = wdata_r;
      op_mask_s  = mask_r;
    end
  end

  assign rd_word_s    = mem[op_idx_s];
  assign enter_done_s = (next_state_s == DONE) && (state_r != DONE);

  // Byte-lane merge of write data over the current memory word
  always_comb begin
    merged_s = rd_word_s;
    for (int i = 0; i < 4; i++) begin
      if (op_mask_s[i]) begin
        merged_s[8*i +: 8] = op_wdata_s[8*i +: 8];
      end else begin
        merged_s[8*i +: 8] = rd_word_s[8*i +: 8];
      end
    end
  end

  // FSM state, wait counter, captured request and registered bus outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      cnt_r    <= 4'd0;
      wr_r     <= 1'b0;
      idx_r    <= '0;
      wdata_r  <= 32'd0;
      mask_r   <= 4'd0;
      BusReady <= 1'b0;
      HRData   <= 32'd0;
    end else begin
      state_r  <= next_state_s;
      cnt_r    <= cnt_next_s;
      BusReady <= (next_state_s == DONE);
      if (cap_s) begin
        wr_r    <= HWrite;
        idx_r   <= HAddr[IW+1:2];
        wdata_r <= HWData;
        mask_r  <= in_mask_s;
      end
      if (enter_done_s) begin
        HRData <= op_wr_s ? merged_s : rd_word_s;
      end
    end
  end

  // Memory array is never cleared; a write commits only on the edge entering DONE
  always_ff @(posedge clk) begin
    if (!reset && enter_done_s && op_wr_s) begin
      mem[op_idx_s] <= merged_s;
    end
  end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Self-checking bench: LATENCY=2 instance checked every cycle against a transaction-level
// model, plus a LATENCY=0 instance checked with directed literal expectations.
`timescale 1ns/1ps
module tb_mem_bus_responder;
  localparam int WORDS = 1024;
  localparam int LAT0  = 2;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic        req0 = 1'b0, wr0 = 1'b0, req1 = 1'b0, wr1 = 1'b0;
  logic [31:0] addr0 = 32'd0, wd0 = 32'd0, addr1 = 32'd0, wd1 = 32'd0;
  logic [31:0] rd0, rd1;
  logic        rdy0, rdy1;
`ifdef MEMRESP_BYTEMASK_EN
  logic [3:0]  mask0 = 4'hF, mask1 = 4'hF;
`endif
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_bus_responder #(.WORDS(WORDS), .LATENCY(LAT0)) dut0 (
    .clk(clk), .reset(reset), .HRequest(req0), .HWrite(wr0), .HAddr(addr0), .HWData(wd0),
`ifdef MEMRESP_BYTEMASK_EN
    .HByteMask(mask0),
`endif
    .HRData(rd0), .BusReady(rdy0));

  mem_bus_responder #(.WORDS(WORDS), .LATENCY(0)) dut1 (
    .clk(clk), .reset(reset), .HRequest(req1), .HWrite(wr1), .HAddr(addr1), .HWData(wd1),
`ifdef MEMRESP_BYTEMASK_EN
    .HByteMask(mask1),
`endif
    .HRData(rd1), .BusReady(rdy1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Transaction-level model of dut0: memory map, pending op and cycles left to completion
  bit [31:0] mm [int];
  bit        model_on = 1'b0, m_busy = 1'b0, m_ready = 1'b0, m_wr = 1'b0;
  int        m_left = 0, m_idx = 0;
  bit [31:0] m_wd = 32'd0, m_data = 32'd0;
  bit [3:0]  m_mask = 4'hF;

  initial forever begin
    @(negedge clk);
    if (reset) begin
      model_on = 1'b1; m_busy = 1'b0; m_ready = 1'b0; m_data = 32'd0;
      chk("model_rst_ready", {31'd0, rdy0}, 32'd0);
      chk("model_rst_data", rd0, 32'd0);
    end else if (model_on) begin
      chk("model_ready", {31'd0, rdy0}, {31'd0, m_ready});
      chk("model_rdata", rd0, m_data);
      if (m_ready) begin
        m_ready = 1'b0;
      end else if (!m_busy && req0) begin
        m_busy = 1'b1; m_left = LAT0; m_wr = wr0; m_wd = wd0;
        m_idx  = int'((addr0 / 32'd4) % WORDS);
`ifdef MEMRESP_BYTEMASK_EN
        m_mask = mask0;
`else
        m_mask = 4'hF;
`endif
      end else if (m_busy) begin
        m_left--;
      end
      if (m_busy && m_left == 0) begin
        if (m_wr) begin
          bit [31:0] w;
          w = mm.exists(m_idx) ? mm[m_idx] : 32'd0;
          for (int b = 0; b < 4; b++)
            if (m_mask[b]) w[8*b +: 8] = m_wd[8*b +: 8];
          mm[m_idx] = w;
          m_data = w;
        end else begin
          m_data = mm.exists(m_idx) ? mm[m_idx] : 32'd0;
        end
        m_busy = 1'b0; m_ready = 1'b1;
      end
    end
  end

  // One transaction on dut0 (sel=0) or dut1 (sel=1); lat = cycle index of BusReady, -1 on timeout
  task automatic op(input bit sel, input bit w, input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] m, output int lat, output logic [31:0] rd);
    @(posedge clk); #1;
    if (sel) begin
      req1 = 1'b1; wr1 = w; addr1 = a; wd1 = d;
`ifdef MEMRESP_BYTEMASK_EN
      mask1 = m;
`endif
    end else begin
      req0 = 1'b1; wr0 = w; addr0 = a; wd0 = d;
`ifdef MEMRESP_BYTEMASK_EN
      mask0 = m;
`endif
    end
    lat = -1;
    rd  = 32'd0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if ((sel ? rdy1 : rdy0) === 1'b1) begin
        lat = i;
        rd  = sel ? rd1 : rd0;
        break;
      end
    end
    if (sel) req1 = 1'b0; else req0 = 1'b0;
    if (m == 4'hF && lat < 0) $display("op timeout on dut%0d", sel);
  endtask

  initial begin
    int          lat, n, c;
    logic [31:0] rd;
    logic [4:0]  pat;
    int          t [4];
    logic [31:0] dv [4];
    bit          seen;

    // Asynchronous reset mid-cycle, checked before any clock edge
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("t1_ready0_async", {31'd0, rdy0}, 32'd0);
    chk("t1_rdata0_async", rd0, 32'd0);
    chk("t1_ready1_async", {31'd0, rdy1}, 32'd0);
    chk("t1_rdata1_async", rd1, 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    // Write 0xDEADBEEF to 0x10: BusReady only in cycle 3
    @(posedge clk); #1;
    req0 = 1'b1; wr0 = 1'b1; addr0 = 32'h10; wd0 = 32'hDEADBEEF;
    pat = 5'd0;
    for (int k = 0; k < 5; k++) begin
      pat[k] = rdy0;
      if (rdy0) req0 = 1'b0;
      @(posedge clk); #1;
    end
    req0 = 1'b0;
    chk("t2_ready_cycles", {27'd0, pat}, 32'h08);
    op(1'b0, 1'b0, 32'h10, 32'd0, 4'hF, lat, rd);
    chk("t2_read_lat", 32'(lat), 32'd3);
    chk("t2_read_data", rd, 32'hDEADBEEF);

    // Line fill with HRequest held and HAddr advanced on each BusReady
    for (int k = 0; k < 4; k++) op(1'b0, 1'b1, 32'h20 + 32'(4*k), 32'(k+1), 4'hF, lat, rd);
    @(posedge clk); #1;
    req0 = 1'b1; wr0 = 1'b0; addr0 = 32'h20; n = 0; c = 0;
    while (n < 4 && c < 60) begin
      @(posedge clk); #1; c++;
      if (rdy0) begin
        t[n] = c; dv[n] = rd0; n++;
        addr0 = addr0 + 32'd4;
        if (n == 4) req0 = 1'b0;
      end
    end
    req0 = 1'b0;
    chk("t3_pulses", 32'(n), 32'd4);
    chk("t3_first_cycle", 32'(t[0]), 32'd3);
    for (int k = 0; k < 4; k++) chk("t3_data", dv[k], 32'(k+1));
    for (int k = 1; k < 4; k++) chk("t3_spacing", 32'(t[k] - t[k-1]), 32'(2 + LAT0));

    // Address aliasing above the index and ignored byte offset
    op(1'b0, 1'b1, 32'h10, 32'h55, 4'hF, lat, rd);
    chk("t4_write_echo", rd, 32'h55);
    op(1'b0, 1'b0, 32'h1010, 32'd0, 4'hF, lat, rd);
    chk("t4_alias_data", rd, 32'h55);
    op(1'b0, 1'b0, 32'h13, 32'd0, 4'hF, lat, rd);
    chk("t4_lowbits_data", rd, 32'h55);

    // Reset during WAIT abandons the write
    op(1'b0, 1'b1, 32'h40, 32'h9, 4'hF, lat, rd);
    @(posedge clk); #1;
    req0 = 1'b1; wr0 = 1'b1; addr0 = 32'h40; wd0 = 32'h1234;
    @(posedge clk); #1;
    req0 = 1'b0;
    #2 reset = 1'b1;
    seen = 1'b0;
    repeat (2) begin @(posedge clk); #1; if (rdy0) seen = 1'b1; end
    reset = 1'b0;
    repeat (5) begin @(posedge clk); #1; if (rdy0) seen = 1'b1; end
    chk("t5_no_pulse", {31'd0, seen}, 32'd0);
    op(1'b0, 1'b0, 32'h40, 32'd0, 4'hF, lat, rd);
    chk("t5_read_lat", 32'(lat), 32'd3);
    chk("t5_read_data", rd, 32'h9);

    // LATENCY = 0 instance
    op(1'b1, 1'b1, 32'h30, 32'hAABBCCDD, 4'hF, lat, rd);
    chk("t6_write_lat", 32'(lat), 32'd1);
`ifdef MEMRESP_BYTEMASK_EN
    op(1'b1, 1'b1, 32'h30, 32'h11223344, 4'b0011, lat, rd);
    chk("t6_mask_echo", rd, 32'hAABB3344);
    op(1'b1, 1'b0, 32'h30, 32'd0, 4'hF, lat, rd);
    chk("t6_read_lat", 32'(lat), 32'd1);
    chk("t6_mask_read", rd, 32'hAABB3344);
`else
    op(1'b1, 1'b0, 32'h30, 32'd0, 4'hF, lat, rd);
    chk("t6_read_lat", 32'(lat), 32'd1);
    chk("t6_read_data", rd, 32'hAABBCCDD);
`endif

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
